// File: rtl/core_pkg.sv
// Shared decode definitions: RV32I base opcodes, instruction-type flags
// and the entry format carried through the decode stage.
package core_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic r_type;
        logic i_type;
        logic store;
        logic load;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic illegal;
    } instr_type_t;

    typedef struct packed {
        instr_type_t itype;
        logic [31:0] instr;
        logic [31:0] pc;
    } dec_entry_t;

endpackage

// File: rtl/opcode_type_decode.sv
// Combinational opcode-to-type decoder; exactly one flag is set for any opcode.
module opcode_type_decode
    import core_pkg::*;
(
    input  logic [6:0]  opcode,
    output instr_type_t itype
);

    always_comb begin
        itype = '0;
        unique case (opcode)
            OPC_R:      itype.r_type  = 1'b1;
            OPC_I:      itype.i_type  = 1'b1;
            OPC_LOAD:   itype.load    = 1'b1;
            OPC_STORE:  itype.store   = 1'b1;
            OPC_BRANCH: itype.branch  = 1'b1;
            OPC_JAL:    itype.jal     = 1'b1;
            OPC_JALR:   itype.jalr    = 1'b1;
            OPC_LUI:    itype.lui     = 1'b1;
            OPC_AUIPC:  itype.auipc   = 1'b1;
            default:    itype.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_type_decode_stage.sv
// Registered instruction-type decode stage with a 2-entry skid buffer
// between fetch and the ALU-op generator.
module instr_type_decode_stage
    import core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        r_type_o,
    output logic        i_type_o,
    output logic        store_o,
    output logic        load_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        lui_o,
    output logic        auipc_o,
    output logic        illegal_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    dec_entry_t  main_q, main_d;
    dec_entry_t  skid_q, skid_d;
    dec_entry_t  new_entry;
    instr_type_t in_type;
    logic        main_valid, skid_valid;
    logic        in_hs, out_hs;

    opcode_type_decode u_dec (
        .opcode (instr_i[6:0]),
        .itype  (in_type)
    );

    assign new_entry  = '{itype: in_type, instr: instr_i, pc: pc_i};
    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == SKID);

    assign instr_ready_o = ~skid_valid;
    assign out_valid_o   = main_valid;
    assign in_hs         = instr_valid_i & instr_ready_o;
    assign out_hs        = out_valid_o & out_ready_i;

    // Invalid entries are zeroed so the outputs read 0 straight from flops.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        main_d  = new_entry;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (in_hs && out_hs) begin
                        main_d = new_entry;
                    end else if (out_hs) begin
                        main_d  = '0;
                        state_d = EMPTY;
                    end else if (in_hs) begin
                        skid_d  = new_entry;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (out_hs) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign r_type_o  = main_q.itype.r_type;
    assign i_type_o  = main_q.itype.i_type;
    assign store_o   = main_q.itype.store;
    assign load_o    = main_q.itype.load;
    assign branch_o  = main_q.itype.branch;
    assign jal_o     = main_q.itype.jal;
    assign jalr_o    = main_q.itype.jalr;
    assign lui_o     = main_q.itype.lui;
    assign auipc_o   = main_q.itype.auipc;
    assign illegal_o = main_q.itype.illegal;
    assign instr_o   = main_q.instr;
    assign pc_o      = main_q.pc;

endmodule

// File: tb/tb_instr_type_decode_stage.sv
// Bench for instr_type_decode_stage: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_instr_type_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        r_type, i_type, store, load, branch, jal, jalr, lui, auipc, illegal;
    logic [31:0] instr_out, pc_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    instr_type_decode_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_i       (instr),
        .pc_i          (pc),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .r_type_o      (r_type),
        .i_type_o      (i_type),
        .store_o       (store),
        .load_o        (load),
        .branch_o      (branch),
        .jal_o         (jal),
        .jalr_o        (jalr),
        .lui_o         (lui),
        .auipc_o       (auipc),
        .illegal_o     (illegal),
        .instr_o       (instr_out),
        .pc_o          (pc_out)
    );

    logic [9:0] flags;
    assign flags = {r_type, i_type, store, load, branch, jal, jalr, lui, auipc, illegal};

    // Flag bit order {r,i,store,load,branch,jal,jalr,lui,auipc,illegal}:
    // opcode table index k sets bit 9-k; no match sets the illegal bit.
    function automatic logic [9:0] exp_flags(input logic [31:0] w);
        logic [6:0] tbl [9];
        logic [9:0] f;
        tbl = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        f = 10'b0000000001;
        for (int k = 0; k < 9; k++)
            if (w[6:0] == tbl[k]) f = 10'b1000000000 >> k;
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of accepted {instr,pc}, capacity 2; head is presented.
    logic [63:0] mq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            automatic bit m_in  = instr_valid && (mq.size() < 2);
            automatic bit m_out = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out) void'(mq.pop_front());
                if (m_in) mq.push_back({instr, pc});
            end
        end
    end

    always @(negedge clk) begin
        if (mq.size() == 0) begin
            chk("model_valid", {63'd0, out_valid}, 64'd0);
            chk("model_idle_data", {flags, instr_out, pc_out}, 64'd0);
        end else begin
            chk("model_valid", {63'd0, out_valid}, 64'd1);
            chk("model_entry", {instr_out, pc_out}, mq[0]);
            chk("model_flags", {54'd0, flags}, {54'd0, exp_flags(mq[0][63:32])});
        end
        chk("model_ready", {63'd0, instr_ready}, {63'd0, (mq.size() < 2)});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] p);
        instr = w;
        pc = p;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    logic [31:0] seq_w [4];
    logic [9:0]  seq_f [4];

    initial begin
        seq_w = '{32'h00000013, 32'h0002A303, 32'h0062A023, 32'h0000006F};
        seq_f = '{10'b0100000000, 10'b0001000000, 10'b0010000000, 10'b0000010000};

        // Reset state
        #3;
        chk("rst_ready", {63'd0, instr_ready}, 64'd1);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_ready", {63'd0, instr_ready}, 64'd1);

        // Single R-type
        send(32'h00B50533, 32'h100);
        chk("r_valid", {63'd0, out_valid}, 64'd1);
        chk("r_flags", {54'd0, flags}, {54'd0, 10'b1000000000});
        chk("r_pc", {32'd0, pc_out}, 64'h100);
        tick();

        // Back-to-back, one output per cycle
        for (int i = 0; i < 4; i++) begin
            instr = seq_w[i];
            pc = 32'h200 + 32'(4 * i);
            instr_valid = 1'b1;
            tick();
            chk("b2b_valid", {63'd0, out_valid}, 64'd1);
            chk("b2b_flags", {54'd0, flags}, {54'd0, seq_f[i]});
            chk("b2b_instr", {32'd0, instr_out}, {32'd0, seq_w[i]});
        end
        instr_valid = 1'b0;
        tick();
        chk("b2b_drain", {63'd0, out_valid}, 64'd0);

        // Backpressure into SKID, then drain in order
        out_ready = 1'b0;
        send(32'h000080E7, 32'h300);
        chk("bp_ready1", {63'd0, instr_ready}, 64'd1);
        send(32'h123452B7, 32'h304);
        chk("bp_ready2", {63'd0, instr_ready}, 64'd0);
        chk("bp_jalr", {54'd0, flags}, {54'd0, 10'b0000001000});
        tick();
        chk("bp_hold", {54'd0, flags}, {54'd0, 10'b0000001000});
        out_ready = 1'b1;
        tick();
        chk("bp_lui", {54'd0, flags}, {54'd0, 10'b0000000100});
        chk("bp_lui_pc", {32'd0, pc_out}, 64'h304);
        chk("bp_ready3", {63'd0, instr_ready}, 64'd1);
        tick();
        chk("bp_drain", {63'd0, out_valid}, 64'd0);

        // Illegal opcodes, including low bits != 2'b11
        send(32'h00000000, 32'h400);
        chk("ill0", {54'd0, flags}, {54'd0, 10'b0000000001});
        send(32'h0000007F, 32'h404);
        chk("ill7f", {54'd0, flags}, {54'd0, 10'b0000000001});
        tick();

        // Flush in SKID with a pending input
        out_ready = 1'b0;
        send(32'h00000013, 32'h500);
        send(32'h00000033, 32'h504);
        chk("fl_skid_ready", {63'd0, instr_ready}, 64'd0);
        flush = 1'b1;
        instr = 32'h00000017;
        instr_valid = 1'b1;
        tick();
        flush = 1'b0;
        instr_valid = 1'b0;
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, instr_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_no_auipc", {63'd0, out_valid}, 64'd0);

        // Flush in FULL drops an accepted-looking input
        out_ready = 1'b0;
        send(32'h00000013, 32'h600);
        flush = 1'b1;
        instr = 32'h00000017;
        instr_valid = 1'b1;
        tick();
        flush = 1'b0;
        instr_valid = 1'b0;
        chk("flf_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("flf_still_empty", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset while FULL
        send(32'h00B50533, 32'h700);
        chk("ar_pre", {63'd0, out_valid}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_flags", {54'd0, flags}, 64'd0);
        chk("ar_data", {instr_out, pc_out}, 64'd0);
        chk("ar_ready", {63'd0, instr_ready}, 64'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h0062A023, 32'h800);
        chk("ar_after", {54'd0, flags}, {54'd0, 10'b0010000000});
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
